// File: rtl/rr_resp_arbiter.sv
// Round-robin merge of NumIn valid/ready request streams onto one target port.
// Emits the winning initiator index with the payload; optional one-entry output register.
module rr_resp_arbiter #(
  parameter int unsigned NumIn     = 32,
  parameter int unsigned DataWidth = 32,
  parameter bit          AxiVldRdy = 1'b1,
  parameter bit          OutReg    = 1'b0,
  parameter int unsigned NumInLog  = (NumIn == 1) ? 1 : $clog2(NumIn)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumIn-1:0]                valid_i,
  output logic [NumIn-1:0]                ready_o,
  input  logic [NumIn-1:0][DataWidth-1:0] data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [DataWidth-1:0]            data_o,
  output logic [NumInLog-1:0]             idx_o
);

  if (NumIn == 0) begin : g_bad_param
    $fatal(1, "rr_resp_arbiter: NumIn must be greater than zero");
  end

  logic                any_valid;
  logic [NumInLog-1:0] rr_q;
  logic [NumInLog-1:0] arb_idx;
  logic [NumInLog-1:0] win_idx;
  logic [NumInLog-1:0] next_rr;
  logic                accept;

  assign any_valid = |valid_i;

  // Prefer the lowest valid index at or above the pointer; otherwise wrap to
  // the lowest valid index overall. Wrap is at NumIn, not 2**NumInLog.
  always_comb begin
    logic [NumInLog-1:0] hi_idx;
    logic [NumInLog-1:0] lo_idx;
    logic                hi_found;
    // NOTE: every always_comb variable gets a default before any branch so no path can infer a latch.
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        lo_idx = NumInLog'(i);
        if (i >= int'(rr_q)) begin
          hi_idx   = NumInLog'(i);
          hi_found = 1'b1;
        end
      end
    end
    arb_idx = hi_found ? hi_idx : lo_idx;
  end

  assign next_rr = (win_idx == NumInLog'(NumIn - 1)) ? '0 : win_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= next_rr;
    end
  end

  assign ready_o = accept ? (NumIn'(1) << win_idx) : '0;

  if (OutReg) begin : g_out_reg
    logic                 full_q;
    logic [DataWidth-1:0] data_q;
    logic [NumInLog-1:0]  idx_q;

    assign win_idx = arb_idx;
    assign accept  = any_valid & (~full_q | ready_i);

    // A simultaneous drain and fill keeps the register full.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        full_q <= 1'b0;
      end else if (accept) begin
        full_q <= 1'b1;
      end else if (ready_i) begin
        full_q <= 1'b0;
      end
    end

    // NOTE: payload registers carry no reset; full_q alone says whether they hold a beat.
    always_ff @(posedge clk_i) begin
      if (accept) begin
        data_q <= data_i[win_idx];
        idx_q  <= win_idx;
      end
    end

    assign valid_o = full_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

    a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i) |=> ($stable(data_o) && $stable(idx_o)));

  end else begin : g_comb_out
    logic                lock_q;
    logic [NumInLog-1:0] lock_idx_q;

    if (AxiVldRdy) begin : g_lock
      // A stalled winner keeps the grant until its handshake completes.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          lock_q <= 1'b0;
        end else if (any_valid) begin
          lock_q <= ~ready_i;
        end
      end

      always_ff @(posedge clk_i) begin
        if (any_valid && !ready_i) begin
          lock_idx_q <= win_idx;
        end
      end

      a_lock_hold : assert property (@(posedge clk_i) disable iff (rst_i)
        lock_q |-> valid_i[lock_idx_q]);
    end else begin : g_no_lock
      assign lock_q     = 1'b0;
      assign lock_idx_q = '0;
    end

    assign win_idx = lock_q ? lock_idx_q : arb_idx;
    assign accept  = any_valid & ready_i;
    assign valid_o = any_valid;
    assign data_o  = data_i[win_idx];
    assign idx_o   = win_idx;
  end

  a_ready_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ready_o));

endmodule

// File: tb/tb_rr_resp_arbiter.sv
// Randomized bench for rr_resp_arbiter: three configurations checked every cycle
// against a round-robin model, plus directed sequences with literal expectations.
module tb_rr_resp_arbiter;

  localparam int DW   = 16;
  localparam int NDUT = 3;
  localparam int MAXN = 5;
  localparam int NA   = 4;
  localparam int NB   = 5;
  localparam int NC   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NA-1:0]         a_valid, a_ready;
  logic [NA-1:0][DW-1:0] a_data;
  logic                  a_vo, a_ri;
  logic [DW-1:0]         a_do;
  logic [1:0]            a_idx;

  logic [NB-1:0]         b_valid, b_ready;
  logic [NB-1:0][DW-1:0] b_data;
  logic                  b_vo, b_ri;
  logic [DW-1:0]         b_do;
  logic [2:0]            b_idx;

  logic [NC-1:0]         c_valid, c_ready;
  logic [NC-1:0][DW-1:0] c_data;
  logic                  c_vo, c_ri;
  logic [DW-1:0]         c_do;
  logic [0:0]            c_idx;

  rr_resp_arbiter #(.NumIn(NA), .DataWidth(DW), .AxiVldRdy(1'b1), .OutReg(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .ready_o(a_ready), .data_i(a_data),
    .valid_o(a_vo), .ready_i(a_ri), .data_o(a_do), .idx_o(a_idx));

  rr_resp_arbiter #(.NumIn(NB), .DataWidth(DW), .AxiVldRdy(1'b0), .OutReg(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .ready_o(b_ready), .data_i(b_data),
    .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do), .idx_o(b_idx));

  rr_resp_arbiter #(.NumIn(NC), .DataWidth(DW), .AxiVldRdy(1'b1), .OutReg(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .valid_i(c_valid), .ready_o(c_ready), .data_i(c_data),
    .valid_o(c_vo), .ready_i(c_ri), .data_o(c_do), .idx_o(c_idx));

  int total = 0;
  int bad   = 0;

  // Stimulus per configuration
  bit            v   [NDUT][MAXN];
  logic [DW-1:0] d   [NDUT][MAXN];
  bit            rdy [NDUT];

  // Model state: fairness pointer, the stalled claim, the registered beat
  int            ptr      [NDUT];
  bit            lock     [NDUT];
  int            lock_idx [NDUT];
  bit            full     [NDUT];
  int            q_idx    [NDUT];
  logic [DW-1:0] q_data   [NDUT];

  bit            e_valid [NDUT];
  int            e_ready [NDUT];
  int            e_idx   [NDUT];
  logic [DW-1:0] e_data  [NDUT];
  int            win     [NDUT];
  bit            any     [NDUT];

  logic [31:0] act_valid [NDUT];
  logic [31:0] act_ready [NDUT];
  logic [31:0] act_idx   [NDUT];
  logic [31:0] act_data  [NDUT];

  function automatic int n_of(input int k);
    return (k == 0) ? NA : (k == 1) ? NB : NC;
  endfunction

  function automatic bit axi_of(input int k);
    return k != 1;
  endfunction

  function automatic bit oreg_of(input int k);
    return k == 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_v(input int k, input int pattern);
    for (int i = 0; i < MAXN; i++) v[k][i] = (i < n_of(k)) ? pattern[i] : 1'b0;
  endtask

  task automatic apply();
    for (int i = 0; i < NA; i++) begin a_valid[i] = v[0][i]; a_data[i] = d[0][i]; end
    for (int i = 0; i < NB; i++) begin b_valid[i] = v[1][i]; b_data[i] = d[1][i]; end
    for (int i = 0; i < NC; i++) begin c_valid[i] = v[2][i]; c_data[i] = d[2][i]; end
    a_ri = rdy[0];
    b_ri = rdy[1];
    c_ri = rdy[2];
  endtask

  task automatic sample();
    act_valid[0] = 32'(a_vo); act_ready[0] = 32'(a_ready); act_idx[0] = 32'(a_idx); act_data[0] = 32'(a_do);
    act_valid[1] = 32'(b_vo); act_ready[1] = 32'(b_ready); act_idx[1] = 32'(b_idx); act_data[1] = 32'(b_do);
    act_valid[2] = 32'(c_vo); act_ready[2] = 32'(c_ready); act_idx[2] = 32'(c_idx); act_data[2] = 32'(c_do);
  endtask

  // Expected outputs for this cycle from the current inputs and model state
  task automatic model_eval(input int k);
    int n;
    int w;
    n = n_of(k);
    any[k] = 1'b0;
    for (int i = 0; i < n; i++) any[k] = any[k] | v[k][i];
    w = -1;
    if (!oreg_of(k) && axi_of(k) && lock[k]) begin
      w = lock_idx[k];
    end else begin
      for (int s = 0; s < n; s++) begin
        if (w < 0 && v[k][(ptr[k] + s) % n]) w = (ptr[k] + s) % n;
      end
    end
    if (w < 0) w = 0;
    win[k] = w;
    if (!oreg_of(k)) begin
      e_valid[k] = any[k];
      e_idx[k]   = w;
      e_data[k]  = d[k][w];
      e_ready[k] = (any[k] && rdy[k]) ? (1 << w) : 0;
    end else begin
      e_valid[k] = full[k];
      e_idx[k]   = q_idx[k];
      e_data[k]  = q_data[k];
      e_ready[k] = (any[k] && (!full[k] || rdy[k])) ? (1 << w) : 0;
    end
  endtask

  task automatic model_commit(input int k);
    bit taken;
    taken = (e_ready[k] != 0);
    if (rst) begin
      ptr[k]  = 0;
      lock[k] = 1'b0;
      full[k] = 1'b0;
    end else if (!oreg_of(k)) begin
      if (taken) begin
        ptr[k]  = (win[k] + 1) % n_of(k);
        lock[k] = 1'b0;
      end else if (any[k] && axi_of(k)) begin
        lock[k]     = 1'b1;
        lock_idx[k] = win[k];
      end
    end else begin
      if (taken) begin
        ptr[k]    = (win[k] + 1) % n_of(k);
        full[k]   = 1'b1;
        q_idx[k]  = win[k];
        q_data[k] = d[k][win[k]];
      end else if (rdy[k]) begin
        full[k] = 1'b0;
      end
    end
  endtask

  task automatic compare(input int k);
    string nm;
    nm = (k == 0) ? "a" : (k == 1) ? "b" : "c";
    check($sformatf("%s valid_o", nm), act_valid[k], 32'(e_valid[k]));
    check($sformatf("%s ready_o", nm), act_ready[k], e_ready[k]);
    if (e_valid[k]) begin
      check($sformatf("%s idx_o", nm), act_idx[k], e_idx[k]);
      check($sformatf("%s data_o", nm), act_data[k], 32'(e_data[k]));
    end
  endtask

  task automatic eval_cycle();
    apply();
    #1;
    sample();
    for (int k = 0; k < NDUT; k++) model_eval(k);
    for (int k = 0; k < NDUT; k++) compare(k);
  endtask

  task automatic end_cycle();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_commit(k);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < MAXN; i++) begin v[k][i] = 1'b0; d[k][i] = '0; end
      rdy[k] = 1'b0; ptr[k] = 0; lock[k] = 1'b0; lock_idx[k] = 0;
      full[k] = 1'b0; q_idx[k] = 0; q_data[k] = '0;
    end
    apply();
    @(negedge clk);

    // Reset state
    eval_cycle();
    check("reset c valid_o", act_valid[2], 0);
    check("reset a ready_o", act_ready[0], 0);
    end_cycle();
    rst = 1'b0;

    // All four requesting, target always ready: strict rotation
    for (int i = 0; i < NA; i++) d[0][i] = DW'(16'hA000 + i);
    set_v(0, 'b1111);
    rdy[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      eval_cycle();
      check("rotate idx_o", act_idx[0], j % 4);
      check("rotate ready_o", act_ready[0], 1 << (j % 4));
      end_cycle();
    end

    // Stall holds the grant on idx 1 even when idx 0 joins; then the pointer moves past it
    set_v(0, 'b0110);
    rdy[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j == 1) set_v(0, 'b0111);
      if (j == 3) rdy[0] = 1'b1;
      eval_cycle();
      check("stall idx_o", act_idx[0], 1);
      check("stall data_o", act_data[0], 32'h0000_A001);
      end_cycle();
    end
    eval_cycle();
    check("after stall idx_o", act_idx[0], 2);
    end_cycle();
    set_v(0, 0);
    rdy[0] = 1'b0;

    // Five ports: wrap from 4 to 0
    for (int i = 0; i < NB; i++) d[1][i] = DW'(16'hB000 + i);
    rdy[1] = 1'b1;
    set_v(1, 'b00010);
    eval_cycle();
    check("wrap prime idx_o", act_idx[1], 1);
    end_cycle();
    set_v(1, 'b10001);
    for (int j = 0; j < 4; j++) begin
      eval_cycle();
      check("wrap idx_o", act_idx[1], (j % 2 == 0) ? 4 : 0);
      end_cycle();
    end
    set_v(1, 0);
    rdy[1] = 1'b0;

    // Registered output: latency 1, then one beat per cycle
    for (int i = 0; i < NC; i++) d[2][i] = DW'(16'hC000 + i);
    rdy[2] = 1'b1;
    set_v(2, 'b11);
    eval_cycle();
    check("oreg first valid_o", act_valid[2], 0);
    check("oreg first ready_o", act_ready[2], 1);
    end_cycle();
    for (int j = 1; j < 5; j++) begin
      eval_cycle();
      check("oreg stream valid_o", act_valid[2], 1);
      check("oreg stream idx_o", act_idx[2], (j - 1) % 2);
      check("oreg stream data_o", act_data[2], 32'h0000_C000 + 32'((j - 1) % 2));
      end_cycle();
    end

    // Full register with target stalled refuses new beats
    rdy[2] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      eval_cycle();
      check("oreg hold ready_o", act_ready[2], 0);
      check("oreg hold idx_o", act_idx[2], 0);
      end_cycle();
    end
    rdy[2] = 1'b1;
    eval_cycle();
    check("oreg refill ready_o", act_ready[2], 2);
    end_cycle();

    // Reset with a beat held drops it; lowest valid index wins afterwards
    rst    = 1'b1;
    rdy[2] = 1'b0;
    eval_cycle();
    check("pre-reset valid_o", act_valid[2], 1);
    check("pre-reset idx_o", act_idx[2], 1);
    end_cycle();
    rst    = 1'b0;
    rdy[2] = 1'b1;
    eval_cycle();
    check("post-reset valid_o", act_valid[2], 0);
    check("post-reset ready_o", act_ready[2], 1);
    end_cycle();
    set_v(2, 0);
    rdy[2] = 1'b0;

    // Random traffic; a and c hold each request until it is taken
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NDUT; k++) rdy[k] = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NB; i++) begin
        v[1][i] = 1'($urandom_range(0, 1));
        d[1][i] = DW'($urandom);
      end
      eval_cycle();
      end_cycle();
      for (int k = 0; k < NDUT; k += 2) begin
        for (int i = 0; i < n_of(k); i++) begin
          if (!rst && v[k][i] && ((e_ready[k] >> i) & 1) == 1) v[k][i] = 1'b0;
          if (!v[k][i] && $urandom_range(0, 2) == 0) begin
            v[k][i] = 1'b1;
            d[k][i] = DW'($urandom);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
